muxn_skid: RTL
==============

# muxn_skid

Parametrised N:1 operand-select stage with a registered, back-pressure-tolerant output for the MIPS pipeline datapath. Selects one of NUM_IN WIDTH-bit sources per transfer, e.g. forwarding/operand paths feeding the ALU, and registers the result behind a valid/ready handshake. A two-entry skid buffer sustains full throughput with a registered `in_ready`. A synchronous flush supports branch/hazard squashing.

## Interface
- `WIDTH`, 32, data width of each source and of the output
- `NUM_IN`, 4, number of sources, 2..16; `SEL_W = $clog2(NUM_IN)` is a derived localparam
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low
- `in_data`  in  NUM_IN*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH]
- `in_sel`  in  SEL_W  binary source select, sampled with `in_valid`
- `in_valid`  in  1  upstream offers a transfer
- `in_ready`  out  1  stage accepts; registered output
- `flush`  in  1  synchronous squash of all held entries
- `out_data`  out  WIDTH  selected, registered data
- `out_sel`  out  SEL_W  select captured with `out_data`
- `out_err`  out  1  captured select was ≥ NUM_IN
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  downstream accepts

## Operation
- Accept: `in_valid && in_ready`. Captured payload is {`in_data[in_sel]`, `in_sel`, err}.
- Out-of-range select (`in_sel` ≥ NUM_IN, only possible when NUM_IN is not a power of two): data is 0 and err is 1. The transfer still completes.
- Emit: `out_valid && out_ready`.
- Storage: main register (drives outputs) and skid register, each with its own valid bit.
- States: EMPTY (neither valid), ONE (main only), FULL (main + skid).
  - EMPTY: accept → ONE.
  - ONE: accept without emit → FULL. Emit without accept → EMPTY. Accept with emit → ONE, with the new payload in main. Otherwise hold.
  - FULL: `in_ready` = 0. Emit → ONE, skid moves to main.
- `in_ready` = 1 exactly when the skid is not valid. It is computed from next state and registered.
- Order is strictly FIFO; no payload is dropped or duplicated without a flush.
- `flush` = 1: next state is EMPTY and both valid bits clear. Flush overrides any same-cycle accept, and that accepted payload is discarded. `in_ready` is 1 in the following cycle. Data registers may keep stale values. Outputs other than `out_valid` are don't-care while `out_valid` = 0.
- While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_sel` and `out_err` hold stable.

## Timing
- Reset (asynchronous, `rst_n` = 0): state EMPTY; `out_valid` = 0, `in_ready` = 0, `out_data` = 0, `out_sel` = 0, `out_err` = 0.
- First cycle after reset release: `in_ready` = 1.
- Latency: accept at edge t → `out_valid` = 1 after edge t, if main was empty or was emitting at t.
- Throughput: 1 transfer/cycle sustained while `out_ready` = 1.
- FULL occurs only after downstream stalls with main occupied. At most one extra word is absorbed after `out_ready` falls.
- Same-cycle accept + emit in FULL is impossible because `in_ready` = 0.
- `rst_n` asserted mid-transfer: all entries are lost immediately, with no output glitch beyond the asynchronous clear.
- No combinational path from `in_*` or `out_ready` to any output.

## Test plan
- Reset/idle: hold `rst_n` = 0 → all outputs 0. Release → `in_ready` = 1 on the next cycle and `out_valid` = 0.
- Streaming, WIDTH=32, NUM_IN=4: sources {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel 0,1,2,3 on consecutive cycles, `out_ready` = 1 → outputs 0x11111111..0x44444444, one per cycle, 1-cycle latency, `out_sel` 0..3.
- Back-pressure: stream sel 2,1 with `out_ready` = 0 → `in_ready` falls after two accepts and `out_data` holds 0x33333333. Raise `out_ready` → 0x33333333 then 0x22222222; `in_ready` returns 1.
- Flush: state FULL, assert `flush` together with a valid input → next cycle `out_valid` = 0 and `in_ready` = 1. The flushed input never appears.
- Out-of-range select, NUM_IN=3: `in_sel` = 3 → `out_data` = 0, `out_err` = 1, `out_sel` = 3. Next transfer with sel 1 → `out_err` = 0.
- Async reset with FULL and `out_ready` = 0: pulse `rst_n` low mid-cycle → `out_valid` = 0 immediately. After release, streaming resumes cleanly from sel 0.

Source files
------------

// File: rtl/muxn_skid.sv
// N:1 operand-select stage with a two-entry skid buffer behind a valid/ready handshake.
// The main register drives the outputs; the skid register absorbs one word while downstream stalls.
module muxn_skid #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   sel_data_c;
    logic               sel_err_c;
    logic               accept_c;
    logic               emit_c;
    logic               load_main_c;
    logic               main_from_skid_c;
    logic               load_skid_c;

    logic [WIDTH-1:0]   skid_data;
    logic [SEL_W-1:0]   skid_sel;
    logic               skid_err;

    // Source select; an unmatched select yields zero data with the error flag set.
    always_comb begin
        sel_data_c = '0;
        sel_err_c  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data_c = in_data[k*WIDTH +: WIDTH];
                sel_err_c  = 1'b0;
            end
        end
    end

    assign accept_c = in_valid && in_ready;
    assign emit_c   = out_valid && out_ready;

    // Next-state and register-load decode; flush wins over any same-cycle transfer.
    always_comb begin
        state_next       = state;
        load_main_c      = 1'b0;
        main_from_skid_c = 1'b0;
        load_skid_c      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept_c) begin
                    state_next  = ONE;
                    load_main_c = 1'b1;
                end
            end
            ONE: begin
                if (accept_c && !emit_c) begin
                    state_next  = FULL;
                    load_skid_c = 1'b1;
                end else if (!accept_c && emit_c) begin
                    state_next  = EMPTY;
                end else if (accept_c && emit_c) begin
                    load_main_c = 1'b1;
                end
            end
            FULL: begin
                if (emit_c) begin
                    state_next       = ONE;
                    main_from_skid_c = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
        end
    end

    // State register; in_ready and out_valid are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
        end
    end

    // Payload registers: main refills from the input or from the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_main_c) begin
                out_data <= sel_data_c;
                out_sel  <= in_sel;
                out_err  <= sel_err_c;
            end else if (main_from_skid_c) begin
                out_data <= skid_data;
                out_sel  <= skid_sel;
                out_err  <= skid_err;
            end
            if (load_skid_c) begin
                skid_data <= sel_data_c;
                skid_sel  <= in_sel;
                skid_err  <= sel_err_c;
            end
        end
    end

endmodule
